data_memory_ctrl: RTL
=====================

Name: data_memory_ctrl

Overview:
- Parametrised successor to the flat 64-bit data memory.
- Byte-addressed, word-organised data RAM for the load/store stage, with:
  - sized accesses (byte/half/word/double) and sign/zero extension on loads;
  - alignment and range checking;
  - registered 1-cycle read latency with a valid strobe;
  - a post-reset hardware clear sweep, during which the block is not ready.
- Sits between the execute stage address/data outputs and the writeback mux.

Parameters:
- DATA_W, 64, word width in bits; legal values 32 or 64.
- DEPTH, 1024, number of words; power of two, at least 2.
- ADDR_W, 64, width of the byte address input.
- BYTES, DATA_W/8, derived; bytes per word.
- IDX_W, $clog2(DEPTH), derived; word-index width.
- OFS_W, $clog2(BYTES), derived; byte-offset width.

Ports:
- clk  in  1  clock, rising edge active.
- rst  in  1  asynchronous, active-high reset.
- adr  in  ADDR_W  byte address.
- datain  in  DATA_W  store data, right-justified (bits [8*n-1:0] used for an n-byte access).
- w  in  1  store request.
- r  in  1  load request.
- size  in  2  0=byte, 1=half, 2=word, 3=double.
- uns  in  1  1 = zero-extend load result, 0 = sign-extend.
- ready  out  1  accepts requests this cycle.
- dataout  out  DATA_W  load result, extended.
- valid  out  1  dataout holds a completed load this cycle.
- fault  out  1  the previous cycle's request was rejected.
- fault_code  out  2  1=misaligned, 2=out of range, 3=w and r both set, 0=none.

Behaviour:
- Reset (async assert):
  - outputs: ready=0, valid=0, fault=0, fault_code=0, dataout=0;
  - FSM goes to CLEAR with the clear index at 0;
  - memory contents are not reset directly.
- FSM states and transitions:
  - CLEAR: each cycle writes 0 to word[clear_idx] and increments clear_idx; after writing word DEPTH-1, goes to IDLE. Exactly DEPTH cycles from reset deassertion.
  - IDLE: ready=1; requests are accepted.
  - No other states.
- Requests are ignored entirely while ready=0. No fault and no memory change result.
- Address decode:
  - offset = adr[OFS_W-1:0];
  - index = adr[OFS_W+IDX_W-1:OFS_W];
  - bytes n = 1 << size.
- Check priority, evaluated when w or r is asserted in IDLE:
  - (1) w&r → code 3;
  - (2) size=3 with DATA_W=32, or offset not a multiple of n → code 1;
  - (3) any adr bit at or above OFS_W+IDX_W set → code 2;
  - otherwise the request is legal.
- A rejected request:
  - performs no write;
  - asserts valid=0 and fault=1 with fault_code on the next cycle.
- fault and valid are single-cycle pulses; they are never both 1.
- Store (legal):
  - datain[8*n-1:0] is written into bytes offset..offset+n-1 of word[index] at the clock edge;
  - other bytes are unchanged (per-byte write enables, no read-modify-write).
- Load (legal):
  - the RAM word is registered at the edge;
  - next cycle: valid=1 and dataout = bytes offset..offset+n-1, right-justified;
  - upper bits are sign-filled from the top loaded bit if uns=0, zero-filled if uns=1;
  - for size=3, uns has no effect.
- dataout holds its last value when valid=0.
- Loads are back-to-back capable, one result per cycle.
- Load from the word stored in the immediately preceding cycle returns the new data (write-first ordering through the array).
- Reset mid-sweep or mid-load:
  - the in-flight valid is dropped;
  - the sweep restarts from index 0.

Decomposition:
- Package data_mem_pkg holds:
  - enum size_e {SZ_B, SZ_H, SZ_W, SZ_D};
  - enum fault_e {F_NONE, F_MISALIGN, F_RANGE, F_CONFLICT};
  - function extend(data, size, uns) for load extension.
- One sub-module, dmem_bytewise_ram:
  - DEPTH x BYTES byte lanes;
  - per-byte write enables;
  - synchronous read;
  - no reset.

Test Plan:
- Reset, then count cycles → ready rises exactly DEPTH cycles after rst falls; a read of word 5 (adr=0x28, size=3) returns 0 with valid=1 one cycle later.
- Store adr=0x50 size=3 datain=64'h0000ABCDEFFEDCBA, then load adr=0x50 size=3 → next cycle valid=1, dataout=64'h0000ABCDEFFEDCBA.
- Sized extension:
  - store byte 8'hF0 at adr=0x53, then load adr=0x53 size=0 → uns=0 gives 64'hFFFFFFFFFFFFFFF0, uns=1 gives 64'h00000000000000F0;
  - bytes 0x50-0x52 and 0x54-0x57 are unchanged.
- Faults:
  - load adr=0x51 size=1 → fault=1, code=1, valid=0;
  - store at adr=DEPTH*8 → code=2 and no wrap into word 0;
  - w=r=1 → code=3.
- Back-to-back loads adr 0x00, 0x08, 0x10 on consecutive cycles → three consecutive valid pulses with matching data.
- Assert rst midway through the clear sweep → ready stays 0 for a full DEPTH cycles after release; stimulus during CLEAR causes no fault.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the load/store data memory controller.
package data_mem_pkg;

    // Access size as encoded on the size input.
    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } size_e;

    // Reason a request was rejected, as reported on fault_code.
    typedef enum logic [1:0] {
        F_NONE,
        F_MISALIGN,
        F_RANGE,
        F_CONFLICT
    } fault_e;

    // Controller states: sweep the array to zero after reset, then serve requests.
    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_e;

    // Widest word the extension helper handles; narrower words are zero-padded in.
    localparam int MAX_W = 64;

    // Takes right-justified load data and sign- or zero-fills everything above the loaded bytes.
    function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] data,
                                                input size_e           sz,
                                                input logic            uns);
        logic [MAX_W-1:0] ext;
        case (sz)
            SZ_B:    ext = uns ? {56'd0, data[7:0]}  : {{56{data[7]}},  data[7:0]};
            SZ_H:    ext = uns ? {48'd0, data[15:0]} : {{48{data[15]}}, data[15:0]};
            SZ_W:    ext = uns ? {32'd0, data[31:0]} : {{32{data[31]}}, data[31:0]};
            default: ext = data;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/dmem_bytewise_ram.sv
// Word-organised RAM built from byte lanes: per-byte write enables and a
// registered read port. No reset; contents are zeroed by the controller's sweep.
module dmem_bytewise_ram #(
    parameter int DEPTH = 1024,
    parameter int BYTES = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic [BYTES-1:0]     we,
    input  logic [IDX_W-1:0]     widx,
    input  logic [8*BYTES-1:0]   wdata,
    input  logic                 re,
    input  logic [IDX_W-1:0]     ridx,
    output logic [8*BYTES-1:0]   rdata
);

    logic [BYTES-1:0][7:0] mem [DEPTH];

    // Byte-lane writes and a registered read that only updates on a read enable.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (we[b]) begin
                mem[widx][b] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata <= mem[ridx];
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory for the load/store stage: sized accesses with
// sign/zero extension, alignment and range checks, 1-cycle load latency and
// a post-reset clear sweep during which no requests are accepted.
module data_memory_ctrl
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] datain,
    input  logic              w,
    input  logic              r,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic              ready,
    output logic [DATA_W-1:0] dataout,
    output logic              valid,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFS_W = $clog2(BYTES);
    localparam int HI    = OFS_W + IDX_W;

    state_e            state;
    logic [IDX_W-1:0]  clear_idx;
    fault_e            fault_q;

    logic [OFS_W-1:0]  offset;
    logic [IDX_W-1:0]  index;
    size_e             req_size;
    int                nbytes;
    logic              misalign;
    logic              out_range;
    fault_e            req_fault;
    logic              accept;
    logic              legal_st;
    logic              legal_ld;
    logic [BYTES-1:0]  be;
    logic [DATA_W-1:0] wr_lane;

    logic              clearing;
    logic [BYTES-1:0]  ram_we;
    logic [IDX_W-1:0]  ram_widx;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] rd_data;

    logic [OFS_W-1:0]  off_q;
    size_e             size_q;
    logic              uns_q;
    logic [DATA_W-1:0] lane_data;
    logic [DATA_W-1:0] load_result;
    logic [DATA_W-1:0] held;

    assign offset     = adr[OFS_W-1:0];
    assign index      = adr[HI-1:OFS_W];
    assign req_size   = size_e'(size);
    assign clearing   = (state == ST_CLEAR);
    assign fault_code = fault_q;

    // Decode the request: priority-ordered fault check, byte lanes touched and lane-aligned store data.
    always_comb begin
        nbytes    = 1 << size;
        misalign  = ((req_size == SZ_D) && (DATA_W == 32)) ||
                    ((int'(offset) & (nbytes - 1)) != 0);
        out_range = |(adr >> HI);
        req_fault = F_NONE;
        if (w && r) begin
            req_fault = F_CONFLICT;
        end else if (misalign) begin
            req_fault = F_MISALIGN;
        end else if (out_range) begin
            req_fault = F_RANGE;
        end
        accept   = (state == ST_IDLE) && (w || r);
        legal_st = accept && (req_fault == F_NONE) && w;
        legal_ld = accept && (req_fault == F_NONE) && r;
        for (int b = 0; b < BYTES; b++) begin
            be[b] = (b >= int'(offset)) && (b < int'(offset) + nbytes);
        end
        wr_lane = datain << {offset, 3'b000};
    end

    // The sweep owns the write port while clearing; afterwards only legal stores write.
    always_comb begin
        ram_we    = '0;
        ram_widx  = index;
        ram_wdata = wr_lane;
        if (clearing) begin
            ram_we    = '1;
            ram_widx  = clear_idx;
            ram_wdata = '0;
        end else if (legal_st) begin
            ram_we    = be;
        end
    end

    dmem_bytewise_ram #(
        .DEPTH (DEPTH),
        .BYTES (BYTES),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .widx  (ram_widx),
        .wdata (ram_wdata),
        .re    (legal_ld),
        .ridx  (index),
        .rdata (rd_data)
    );

    // Controller FSM: clear sweep, then accept requests and emit single-cycle valid/fault pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clear_idx <= '0;
            ready     <= 1'b0;
            valid     <= 1'b0;
            fault     <= 1'b0;
            fault_q   <= F_NONE;
            off_q     <= '0;
            size_q    <= SZ_B;
            uns_q     <= 1'b0;
        end else begin
            valid   <= 1'b0;
            fault   <= 1'b0;
            fault_q <= F_NONE;
            case (state)
                ST_CLEAR: begin
                    clear_idx <= clear_idx + IDX_W'(1);
                    if (clear_idx == IDX_W'(DEPTH - 1)) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        if (req_fault != F_NONE) begin
                            fault   <= 1'b1;
                            fault_q <= req_fault;
                        end else if (r) begin
                            valid  <= 1'b1;
                            off_q  <= offset;
                            size_q <= req_size;
                            uns_q  <= uns;
                        end
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Select the loaded bytes from the registered word and extend them to full width.
    always_comb begin
        lane_data   = rd_data >> {off_q, 3'b000};
        load_result = DATA_W'(extend(MAX_W'(lane_data), size_q, uns_q));
    end

    // Remember the last completed load so dataout holds steady between valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held <= '0;
        end else if (valid) begin
            held <= load_result;
        end
    end

    assign dataout = valid ? load_result : held;

endmodule
